// File: rtl/dmiss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmiss_ctrl
// Brief    : D-cache miss refill and uncached IO access controller.
// Revision : 1.0 - initial release
// ============================================================================
module dmiss_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_MemVld,
    input  logic        io_Hit,
    input  logic        io_IsIo,
    input  logic        io_IsStore,
    input  logic [31:0] io_Addr,
    input  logic [31:0] io_WData,
    output logic        io_DmissVld,
    output logic        io_IoBlk,
    output logic        io_BusReqVld,
    input  logic        io_BusReqRdy,
    output logic [31:0] io_BusAddr,
    output logic        io_BusWr,
    output logic [31:0] io_BusWData,
    output logic [1:0]  io_BusLen,
    input  logic        io_BusRspVld,
    input  logic [31:0] io_BusRspData,
    output logic        io_RefillWen,
    output logic [1:0]  io_RefillIdx,
    output logic [31:0] io_RefillData,
    output logic        io_IoRdVld,
    output logic [31:0] io_IoRdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MREQ   = 3'd1,
        S_REFILL = 3'd2,
        S_IOREQ  = 3'd3,
        S_IOWAIT = 3'd4,
        S_IODONE = 3'd5
    } state_t;

    localparam logic [31:0] c_LINE_MASK = 32'hFFFF_FFF0;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_store;
    logic [31:0] r_iodata;

    logic w_miss;
    logic w_ioacc;

    assign w_miss  = io_MemVld & ~io_IsIo & ~io_Hit;
    assign w_ioacc = io_MemVld & io_IsIo;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 2'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_store  <= 1'b0;
            r_iodata <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_miss || w_ioacc) begin
                        r_addr  <= io_Addr;
                        r_wdata <= io_WData;
                        r_store <= io_IsStore;
                    end
                end
                S_MREQ: begin
                    if (io_BusReqRdy) r_cnt <= 2'd0;
                end
                S_REFILL: begin
                    if (io_BusRspVld) r_cnt <= r_cnt + 2'd1;
                end
                S_IOWAIT: begin
                    // A store's write ack carries no data the pipeline may use.
                    if (io_BusRspVld) r_iodata <= r_store ? 32'd0 : io_BusRspData;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next        = r_state;
        io_DmissVld   = 1'b0;
        io_IoBlk      = 1'b0;
        io_BusReqVld  = 1'b0;
        io_BusAddr    = 32'd0;
        io_BusWr      = 1'b0;
        io_BusWData   = 32'd0;
        io_BusLen     = 2'd0;
        io_RefillWen  = 1'b0;
        io_RefillIdx  = 2'd0;
        io_RefillData = 32'd0;
        io_IoRdVld    = 1'b0;
        io_IoRdata    = 32'd0;

        case (r_state)
            S_IDLE: begin
                if (w_miss) begin
                    w_next = S_MREQ;
                end else if (w_ioacc) begin
                    w_next = S_IOREQ;
                end
                io_DmissVld = w_miss;
                io_IoBlk    = w_ioacc;
            end
            S_MREQ: begin
                io_DmissVld  = 1'b1;
                io_BusReqVld = 1'b1;
                io_BusAddr   = r_addr & c_LINE_MASK;
                io_BusLen    = 2'd3;
                if (io_BusReqRdy) w_next = S_REFILL;
            end
            S_REFILL: begin
                io_DmissVld = 1'b1;
                if (io_BusRspVld) begin
                    io_RefillWen  = 1'b1;
                    io_RefillIdx  = r_cnt;
                    io_RefillData = io_BusRspData;
                    if (r_cnt == 2'd3) w_next = S_IDLE;
                end
            end
            S_IOREQ: begin
                io_IoBlk     = 1'b1;
                io_BusReqVld = 1'b1;
                io_BusAddr   = r_addr;
                io_BusWr     = r_store;
                io_BusWData  = r_wdata;
                if (io_BusReqRdy) w_next = S_IOWAIT;
            end
            S_IOWAIT: begin
                io_IoBlk = 1'b1;
                if (io_BusRspVld) w_next = S_IODONE;
            end
            S_IODONE: begin
                io_IoRdVld = 1'b1;
                io_IoRdata = r_iodata;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        // Reset silences every output, including any burst still in flight.
        if (reset) begin
            io_DmissVld   = 1'b0;
            io_IoBlk      = 1'b0;
            io_BusReqVld  = 1'b0;
            io_BusAddr    = 32'd0;
            io_BusWr      = 1'b0;
            io_BusWData   = 32'd0;
            io_BusLen     = 2'd0;
            io_RefillWen  = 1'b0;
            io_RefillIdx  = 2'd0;
            io_RefillData = 32'd0;
            io_IoRdVld    = 1'b0;
            io_IoRdata    = 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmiss_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmiss_ctrl
// Brief    : Scoreboard bench for dmiss_ctrl: bus requests, refill beats, IO completions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmiss_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_MemVld, io_Hit, io_IsIo, io_IsStore;
    logic [31:0] io_Addr, io_WData;
    logic        io_DmissVld, io_IoBlk, io_BusReqVld, io_BusReqRdy;
    logic [31:0] io_BusAddr, io_BusWData;
    logic        io_BusWr;
    logic [1:0]  io_BusLen;
    logic        io_BusRspVld;
    logic [31:0] io_BusRspData;
    logic        io_RefillWen;
    logic [1:0]  io_RefillIdx;
    logic [31:0] io_RefillData;
    logic        io_IoRdVld;
    logic [31:0] io_IoRdata;

    dmiss_ctrl u_dut (
        .clock        (clock),
        .reset        (reset),
        .io_MemVld    (io_MemVld),
        .io_Hit       (io_Hit),
        .io_IsIo      (io_IsIo),
        .io_IsStore   (io_IsStore),
        .io_Addr      (io_Addr),
        .io_WData     (io_WData),
        .io_DmissVld  (io_DmissVld),
        .io_IoBlk     (io_IoBlk),
        .io_BusReqVld (io_BusReqVld),
        .io_BusReqRdy (io_BusReqRdy),
        .io_BusAddr   (io_BusAddr),
        .io_BusWr     (io_BusWr),
        .io_BusWData  (io_BusWData),
        .io_BusLen    (io_BusLen),
        .io_BusRspVld (io_BusRspVld),
        .io_BusRspData(io_BusRspData),
        .io_RefillWen (io_RefillWen),
        .io_RefillIdx (io_RefillIdx),
        .io_RefillData(io_RefillData),
        .io_IoRdVld   (io_IoRdVld),
        .io_IoRdata   (io_IoRdata)
    );

    always #5 clock = ~clock;

    localparam logic [1:0] c_EV_REQ = 2'd0;
    localparam logic [1:0] c_EV_REF = 2'd1;
    localparam logic [1:0] c_EV_IOD = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic [1:0]  len;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [1:0] l);
        exp_t e;
        e.kind = k; e.addr = a; e.data = d; e.wr = w; e.len = l;
        q.push_back(e);
    endtask

    // Monitor: every DUT output event is matched against the oldest expectation.
    always @(negedge clock) begin
        logic       ev;
        logic [1:0] k;
        exp_t       e;
        ev = 1'b1;
        k  = c_EV_REQ;
        if (io_BusReqVld && io_BusReqRdy) k = c_EV_REQ;
        else if (io_RefillWen)            k = c_EV_REF;
        else if (io_IoRdVld)              k = c_EV_IOD;
        else                              ev = 1'b0;
        if (ev) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got kind %0d want none", k);
            end else begin
                e = q.pop_front();
                chk("event_kind", 32'(k), 32'(e.kind));
                case (e.kind)
                    c_EV_REQ: begin
                        chk("req_addr",  io_BusAddr,      e.addr);
                        chk("req_wr",    32'(io_BusWr),   32'(e.wr));
                        chk("req_len",   32'(io_BusLen),  32'(e.len));
                        chk("req_wdata", io_BusWData,     e.data);
                    end
                    c_EV_REF: begin
                        chk("refill_idx",  32'(io_RefillIdx), 32'(e.len));
                        chk("refill_data", io_RefillData,     e.data);
                    end
                    default: chk("io_rdata", io_IoRdata, e.data);
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Drives one response beat per cycle from pat (MSB first); expects refill writes on the 1s.
    task automatic burst(input logic [6:0] pat, input int n, input logic [31:0] base);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            io_BusRspVld  = pat[n-1-i];
            io_BusRspData = base + 32'(i);
            if (pat[n-1-i]) begin
                push(c_EV_REF, 32'd0, base + 32'(i), 1'b0, 2'(k));
                k++;
            end
            #2;
            chk("dmiss_in_refill", 32'(io_DmissVld), 32'd1);
            cyc();
        end
        io_BusRspVld = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        io_MemVld = 0; io_Hit = 0; io_IsIo = 0; io_IsStore = 0;
        io_Addr = 0; io_WData = 0; io_BusReqRdy = 0; io_BusRspVld = 0; io_BusRspData = 0;

        // Reset state, with a miss presented that must stay masked
        repeat (2) @(posedge clock);
        #1;
        io_MemVld = 1; #2;
        chk("rst_dmiss",   32'(io_DmissVld),  32'd0);
        chk("rst_busreq",  32'(io_BusReqVld), 32'd0);
        chk("rst_refwen",  32'(io_RefillWen), 32'd0);
        chk("rst_iordvld", 32'(io_IoRdVld),   32'd0);
        io_IsIo = 1; #1;
        chk("rst_ioblk",   32'(io_IoBlk),     32'd0);

        // Hit load
        cyc();
        reset = 0; io_IsIo = 0; io_Hit = 1; io_Addr = 32'h40; #2;
        chk("hit_dmiss",  32'(io_DmissVld),  32'd0);
        chk("hit_ioblk",  32'(io_IoBlk),     32'd0);
        chk("hit_busreq", 32'(io_BusReqVld), 32'd0);
        cyc(); #2;
        chk("hit_stay_idle", 32'(io_BusReqVld), 32'd0);
        cyc();
        io_MemVld = 0; io_Hit = 0;

        // Load miss at 0x1234, ready after two cycles, four back-to-back beats
        cyc();
        io_MemVld = 1; io_Addr = 32'h0000_1234;
        push(c_EV_REQ, 32'h0000_1230, 32'd0, 1'b0, 2'd3);
        #2;
        chk("miss_detect_dmiss", 32'(io_DmissVld), 32'd1);
        cyc();
        io_Addr = 32'hFFFF_FFFF; io_WData = 32'h9999; #2;
        chk("mreq_busreq", 32'(io_BusReqVld), 32'd1);
        chk("mreq_dmiss",  32'(io_DmissVld),  32'd1);
        cyc(); #2;
        chk("mreq_hold", 32'(io_BusReqVld), 32'd1);
        cyc();
        io_BusReqRdy = 1;
        cyc();
        io_BusReqRdy = 0;
        burst(7'b0001111, 4, 32'hA0A0_0000);
        io_Hit = 1; io_Addr = 32'h0000_1234; #2;
        chk("dmiss_after_last", 32'(io_DmissVld), 32'd1 - 32'd1);
        cyc();
        io_MemVld = 0; io_Hit = 0;

        // Miss with gapped beats; response during the request handshake is ignored
        io_MemVld = 1; io_Addr = 32'h0000_3008;
        push(c_EV_REQ, 32'h0000_3000, 32'd0, 1'b0, 2'd3);
        #2;
        chk("miss2_dmiss", 32'(io_DmissVld), 32'd1);
        cyc();
        io_BusReqRdy = 1; io_BusRspVld = 1; io_BusRspData = 32'h0BAD_0BAD; #2;
        chk("miss2_busreq", 32'(io_BusReqVld), 32'd1);
        cyc();
        io_BusReqRdy = 0;
        burst(7'b1001101, 7, 32'h1000_0000);
        io_Hit = 1; #2;
        chk("gap_dmiss_after", 32'(io_DmissVld), 32'd0);
        cyc();
        io_MemVld = 0; io_Hit = 0;

        // IO load
        io_MemVld = 1; io_IsIo = 1; io_Addr = 32'h1FD0_03F8; io_WData = 0;
        push(c_EV_REQ, 32'h1FD0_03F8, 32'd0, 1'b0, 2'd0);
        #2;
        chk("iold_ioblk", 32'(io_IoBlk),    32'd1);
        chk("iold_dmiss", 32'(io_DmissVld), 32'd0);
        cyc();
        io_BusReqRdy = 1; #2;
        chk("ioreq_ioblk", 32'(io_IoBlk), 32'd1);
        cyc();
        io_BusReqRdy = 0; io_Addr = 0; #2;
        chk("iowait_ioblk",  32'(io_IoBlk),     32'd1);
        chk("iowait_busreq", 32'(io_BusReqVld), 32'd0);
        cyc();
        io_BusRspVld = 1; io_BusRspData = 32'hDEAD_BEEF; io_MemVld = 0;
        push(c_EV_IOD, 32'd0, 32'hDEAD_BEEF, 1'b0, 2'd0);
        cyc();
        io_BusRspVld = 0; #2;
        chk("iodone_ioblk",  32'(io_IoBlk),   32'd0);
        chk("iodone_rdvld",  32'(io_IoRdVld), 32'd1);
        cyc(); #2;
        chk("iodone_one_cycle", 32'(io_IoRdVld), 32'd0);

        // IO store; store data changes after acceptance
        cyc();
        io_MemVld = 1; io_IsIo = 1; io_IsStore = 1; io_Addr = 32'h1FD0_0400; io_WData = 32'h0000_55AA;
        push(c_EV_REQ, 32'h1FD0_0400, 32'h0000_55AA, 1'b1, 2'd0);
        #2;
        chk("iost_ioblk", 32'(io_IoBlk), 32'd1);
        cyc();
        io_MemVld = 0; io_IsStore = 0; io_WData = 0;
        cyc();
        io_BusReqRdy = 1;
        cyc();
        io_BusReqRdy = 0; io_BusRspVld = 1; io_BusRspData = 32'h1234_5678;
        push(c_EV_IOD, 32'd0, 32'd0, 1'b0, 2'd0);
        cyc();
        io_BusRspVld = 0; #2;
        chk("iost_rdvld", 32'(io_IoRdVld), 32'd1);
        cyc(); #2;
        chk("iost_rdvld_off", 32'(io_IoRdVld), 32'd0);

        // Reset after the first refill beat, then stray responses
        cyc();
        io_MemVld = 1; io_IsIo = 0; io_Hit = 0; io_Addr = 32'h0000_2004;
        push(c_EV_REQ, 32'h0000_2000, 32'd0, 1'b0, 2'd3);
        cyc();
        io_BusReqRdy = 1;
        cyc();
        io_BusReqRdy = 0; io_BusRspVld = 1; io_BusRspData = 32'h77; io_MemVld = 0;
        push(c_EV_REF, 32'd0, 32'h77, 1'b0, 2'd0);
        cyc();
        reset = 1; io_BusRspData = 32'h88; #2;
        chk("midrst_refwen", 32'(io_RefillWen), 32'd0);
        chk("midrst_dmiss",  32'(io_DmissVld),  32'd0);
        cyc();
        reset = 0; #2;
        chk("stray1_refwen", 32'(io_RefillWen), 32'd0);
        chk("stray1_dmiss",  32'(io_DmissVld),  32'd0);
        cyc(); #2;
        chk("stray2_refwen", 32'(io_RefillWen), 32'd0);
        cyc();
        io_BusRspVld = 0;

        // New miss after reset refills from index 0
        io_MemVld = 1; io_Addr = 32'h0000_2004;
        push(c_EV_REQ, 32'h0000_2000, 32'd0, 1'b0, 2'd3);
        #2;
        chk("postrst_dmiss", 32'(io_DmissVld), 32'd1);
        cyc();
        io_BusReqRdy = 1;
        cyc();
        io_BusReqRdy = 0;
        burst(7'b0001111, 4, 32'h5000_0000);
        io_MemVld = 0;
        cyc(); cyc();

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmiss_ctrl.md
DMISS_CTRL -- requirements
Module: dmiss_ctrl

Interface
REQ-001 clock  input  1  single clock; all state updates on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 io_MemVld  input  1  MEM-stage load/store valid this cycle.
REQ-004 io_Hit  input  1  D-cache tag hit for the MEM-stage access.
REQ-005 io_IsIo  input  1  access is uncached (IO space).
REQ-006 io_IsStore  input  1  access is a store.
REQ-007 io_Addr  input  32  MEM-stage byte address.
REQ-008 io_WData  input  32  MEM-stage store data.
REQ-009 io_DmissVld  output  1  freeze request to the pipeline controller for a cache miss.
REQ-010 io_IoBlk  output  1  freeze request to the pipeline controller for an IO access.
REQ-011 io_BusReqVld  output  1  bus request valid.
REQ-012 io_BusReqRdy  input  1  bus accepts the request.
REQ-013 io_BusAddr  output  32  bus request address.
REQ-014 io_BusWr  output  1  bus request is a write.
REQ-015 io_BusWData  output  32  bus write data.
REQ-016 io_BusLen  output  2  beats minus one: 3 for a refill, 0 for IO.
REQ-017 io_BusRspVld  input  1  response beat valid (read data or write ack).
REQ-018 io_BusRspData  input  32  response read data.
REQ-019 io_RefillWen  output  1  write one refill word into the D-cache.
REQ-020 io_RefillIdx  output  2  word index within the line.
REQ-021 io_RefillData  output  32  refill word.
REQ-022 io_IoRdVld  output  1  IO access completes this cycle.
REQ-023 io_IoRdata  output  32  IO load data; valid when io_IoRdVld is 1.

Function
REQ-024 States: IDLE, MREQ, REFILL, IOREQ, IOWAIT, IODONE.
REQ-025 Miss = io_MemVld & ~io_IsIo & ~io_Hit; IoAcc = io_MemVld & io_IsIo; both are evaluated only in IDLE.
REQ-026 IDLE: Miss -> MREQ; IoAcc -> IOREQ; otherwise stay in IDLE. On either transition, latch address, store flag and store data.
REQ-027 io_DmissVld = (IDLE & Miss) | MREQ | REFILL; it asserts combinationally in the detection cycle.
REQ-028 io_IoBlk = (IDLE & IoAcc) | IOREQ | IOWAIT; it is 0 in IODONE.
REQ-029 MREQ: io_BusReqVld=1, io_BusAddr = latched address & 0xFFFFFFF0, io_BusWr=0, io_BusLen=3; on io_BusReqRdy go to REFILL with the beat counter cleared.
REQ-030 Store misses refill identically (write-allocate); the store then completes as a hit after the refill.
REQ-031 REFILL: each io_BusRspVld drives io_RefillWen=1, io_RefillIdx=counter and io_RefillData=io_BusRspData, then increments the 2-bit counter.
REQ-032 On the beat with counter==3, go to IDLE.
REQ-033 Back in IDLE, the replayed access hits and io_DmissVld falls the cycle after the last beat.
REQ-034 IOREQ: io_BusReqVld=1, io_BusAddr = latched address (unaligned), io_BusWr = latched store flag, io_BusWData = latched data, io_BusLen=0; on io_BusReqRdy go to IOWAIT.
REQ-035 IOWAIT: on io_BusRspVld, capture io_BusRspData into the IO data register and go to IODONE.
REQ-036 IODONE lasts exactly one cycle, with io_IoRdVld=1, io_IoBlk=0 and io_IoRdata = captured data (0 for stores). No new access is accepted in IODONE; it always goes to IDLE.
REQ-037 io_BusReqVld is held with stable address, data and length until io_BusReqRdy; it is 0 in all other states.
REQ-038 io_BusRspVld is ignored outside REFILL and IOWAIT.
REQ-039 io_RefillWen and io_IoRdVld are 0 whenever no response beat or IODONE applies.
REQ-040 Input changes after acceptance do not affect an access in flight; only latched values are used.
REQ-041 io_BusReqRdy and io_BusRspVld high in the same cycle in MREQ or IOREQ: the response is ignored and only the request handshake counts.

Reset
REQ-042 While reset is high, at the next edge: state goes to IDLE, beat counter to 0, latched address/data and IO data register to 0.
REQ-043 During and after reset, all outputs are 0 except the combinational IDLE terms of REQ-027 and REQ-028, which stay gated by reset to 0.
REQ-044 Reset mid-burst abandons the transfer with no further refill writes; later bus responses are ignored in IDLE.

Verification
REQ-045 Load miss at 0x00001234, rdy after 2 cycles, beats A,B,C,D -> DmissVld=1 from the miss cycle; BusAddr=0x00001230, Len=3; RefillIdx 0..3 with A..D; DmissVld=0 the cycle after beat D.
REQ-046 IO load at 0x1FD003F8, response 0xDEADBEEF -> IoBlk=1 through IOWAIT; one cycle with IoRdVld=1, IoRdata=0xDEADBEEF, IoBlk=0.
REQ-047 IO store 0x55AA to 0x1FD00400 -> BusWr=1, BusWData=0x000055AA, Len=0; after ack, IoRdVld=1 for one cycle with IoRdata=0.
REQ-048 Refill with gaps (rspVld pattern 1,0,0,1,1,0,1) -> exactly 4 RefillWen pulses with indices 0,1,2,3 in order.
REQ-049 Reset asserted after beat 1 of a refill, then 2 stray rspVld -> state IDLE; no RefillWen; DmissVld=0 unless a new miss is presented.
REQ-050 Hit load (MemVld=1, Hit=1) -> DmissVld=0, IoBlk=0, BusReqVld=0; state stays IDLE.
